// File: rtl/ucie_mb_pkg.sv
// Shared mainband definitions: lane-mode encodings, FSM states and beat-count helpers
// used by both the TX mapper and the RX demapper.
package ucie_mb_pkg;

    localparam int unsigned NUM_LANES = 16;

    localparam logic [1:0] LANES_NONE = 2'b00;
    localparam logic [1:0] LANES_0_7  = 2'b01;
    localparam logic [1:0] LANES_8_15 = 2'b10;
    localparam logic [1:0] LANES_0_15 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } demap_state_e;

    function automatic int unsigned beats_8(input int unsigned n_bytes, input int unsigned width);
        return n_bytes / (width / 8) / 8;
    endfunction

    function automatic int unsigned beats_16(input int unsigned n_bytes, input int unsigned width);
        return n_bytes / (width / 8) / 16;
    endfunction

    // Index width that stays legal even when only one entry exists.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lane_to_byte_demapper_if.sv
// Lane-side input bundle and reassembled-frame output of the RX demapper.
interface lane_to_byte_demapper_if
    import ucie_mb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_BYTES = 1024
);
    logic [NUM_LANES-1:0][WIDTH-1:0] lane;
    logic                            valid;
    logic [1:0]                      functional_rx_lanes;
    logic [8*N_BYTES-1:0]            out_data;
    logic                            data_valid;
    logic                            busy;

    modport master (
        output lane, valid, functional_rx_lanes,
        input  out_data, data_valid, busy
    );

    modport slave (
        input  lane, valid, functional_rx_lanes,
        output out_data, data_valid, busy
    );
endinterface

// File: rtl/lane_to_byte_demapper_ctrl.sv
// Beat sequencer: tracks frame progress and the latched lane mode, and tells the
// datapath when and where to store each incoming beat.
module demap_beat_ctrl
    import ucie_mb_pkg::*;
#(
    parameter int unsigned BEATS_8  = 32,
    parameter int unsigned BEATS_16 = 16,
    parameter int unsigned CNT_W    = clog2_min1(BEATS_8)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             valid,
    input  logic [1:0]       mode,
    output logic             wr_en_c,
    output logic [CNT_W-1:0] slot_c,
    output logic             done_c,
    output logic             busy
);

    demap_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       mode_q;
    logic             start_c;
    logic             single_c;
    logic             mode_chg_c;
    logic [CNT_W-1:0] last_c;

    // A frame may open from IDLE or directly in the DONE cycle (no bubble).
    assign start_c    = valid && (mode != LANES_NONE) && (state != ST_COLLECT);
    assign single_c   = (mode == LANES_0_15) ? (BEATS_16 == 1) : (BEATS_8 == 1);
    assign mode_chg_c = (state == ST_COLLECT) && (mode != mode_q);
    assign last_c     = (mode_q == LANES_0_15) ? CNT_W'(BEATS_16 - 1) : CNT_W'(BEATS_8 - 1);
    assign wr_en_c    = start_c || ((state == ST_COLLECT) && valid && !mode_chg_c);
    assign slot_c     = (state == ST_COLLECT) ? cnt : '0;
    assign done_c     = (state == ST_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            mode_q <= LANES_NONE;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_c) begin
                        mode_q <= mode;
                        cnt    <= single_c ? '0 : CNT_W'(1);
                        state  <= single_c ? ST_DONE : ST_COLLECT;
                        busy   <= !single_c;
                    end else begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (mode_chg_c) begin
                        // Mode switched mid-frame: drop the partial frame, beat not consumed.
                        cnt   <= '0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (valid) begin
                        if (cnt == last_c) begin
                            cnt   <= '0;
                            state <= ST_DONE;
                            busy  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lane_to_byte_demapper.sv
// RX mainband demapper: reassembles 8- or 16-lane beats into one N_BYTES frame,
// inverting the TX byte-to-lane order, and presents it with a one-cycle valid.
module lane_to_byte_demapper
    import ucie_mb_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_BYTES = 1024
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    lane_to_byte_demapper_if.slave bus
);

    localparam int unsigned BEATS_8  = beats_8(N_BYTES, WIDTH);
    localparam int unsigned BEATS_16 = beats_16(N_BYTES, WIDTH);
    localparam int unsigned CNT_W    = clog2_min1(BEATS_8);
    localparam int unsigned NCHUNK   = 8 * N_BYTES / WIDTH;
    localparam int unsigned CHUNK_W  = clog2_min1(NCHUNK);
    localparam int unsigned LANE_W   = clog2_min1(NUM_LANES);

    logic                          wr_en_c;
    logic [CNT_W-1:0]              slot_c;
    logic                          done_c;
    logic                          busy;
    logic                          full_c;
    logic                          upper_c;
    logic [NUM_LANES-1:0]          lane_we_c;
    logic [CHUNK_W-1:0]            lane_idx_c [NUM_LANES];
    logic [WIDTH-1:0]              lane_dat_c [NUM_LANES];
    logic [NCHUNK-1:0][WIDTH-1:0]  staging;
    logic [8*N_BYTES-1:0]          out_q;
    logic                          data_valid_q;

    demap_beat_ctrl #(
        .BEATS_8  (BEATS_8),
        .BEATS_16 (BEATS_16),
        .CNT_W    (CNT_W)
    ) u_ctrl (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .valid   (bus.valid),
        .mode    (bus.functional_rx_lanes),
        .wr_en_c (wr_en_c),
        .slot_c  (slot_c),
        .done_c  (done_c),
        .busy    (busy)
    );

    assign full_c  = (bus.functional_rx_lanes == LANES_0_15);
    assign upper_c = (bus.functional_rx_lanes == LANES_8_15);

    // Chunk k of beat c lands at chunk slot c*8+k (8-lane) or c*16+k (16-lane).
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        if (k < 8) begin : g_low
            assign lane_we_c[k]  = wr_en_c;
            assign lane_dat_c[k] = upper_c ? bus.lane[k + 8] : bus.lane[k];
            assign lane_idx_c[k] = full_c ? (CHUNK_W'(slot_c) << 4) + CHUNK_W'(k)
                                          : (CHUNK_W'(slot_c) << 3) + CHUNK_W'(k);
        end else begin : g_high
            assign lane_we_c[k]  = wr_en_c & full_c;
            assign lane_dat_c[k] = bus.lane[k];
            assign lane_idx_c[k] = (CHUNK_W'(slot_c) << 4) + CHUNK_W'(k);
        end
    end

    // Staging is never cleared between frames; every slot is rewritten per frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            staging <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                if (lane_we_c[k[LANE_W-1:0]]) begin
                    staging[lane_idx_c[k[LANE_W-1:0]]] <= lane_dat_c[k[LANE_W-1:0]];
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q        <= '0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= done_c;
            if (done_c) begin
                out_q <= staging;
            end
        end
    end

    assign bus.out_data   = out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy;

endmodule

// File: tb/tb_lane_to_byte_demapper.sv
// Randomized bench: source frames are spread onto lanes in TX order and the
// reassembled output is compared against the original frame.
module tb_lane_to_byte_demapper;
    import ucie_mb_pkg::*;

    localparam int unsigned W   = 32;
    localparam int unsigned NB  = 1024;
    localparam int unsigned FB  = 8 * NB;
    localparam int unsigned NCH = FB / W;
    localparam int unsigned B8  = 32;
    localparam int unsigned B16 = 16;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    lane_to_byte_demapper_if #(.WIDTH(W), .N_BYTES(NB)) bus ();

    lane_to_byte_demapper #(.WIDTH(W), .N_BYTES(NB)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;
    int pulses = 0;
    logic [FB-1:0] frames[$];
    int            pulse_cyc[$];
    logic [FB-1:0] last_frame;

    always @(posedge i_clk) cycle++;

    always @(negedge i_clk) begin
        if (bus.data_valid === 1'b1) begin
            pulses++;
            frames.push_back(bus.out_data);
            pulse_cyc.push_back(cycle);
        end
    end

    function automatic void print_frame_fail(input string name, input logic [FB-1:0] got,
                                             input logic [FB-1:0] exp);
        int j = 0;
        for (int i = 0; i < NCH; i++) begin
            if (got[i*W +: W] !== exp[i*W +: W]) begin
                j = i;
                break;
            end
        end
        $display("FAIL %s: chunk %0d got %h expected %h", name, j, got[j*W +: W], exp[j*W +: W]);
    endfunction

    task automatic gen_random(output logic [FB-1:0] s);
        for (int i = 0; i < NCH; i++) s[i*W +: W] = W'($urandom());
    endtask

    // TX byte-to-lane order: frame word c*L+k rides on lane k (or 8+k) of beat c.
    task automatic set_lanes(input logic [1:0] mode, input int c, input logic [FB-1:0] src,
                             input bit dead_low);
        for (int k = 0; k < 16; k++)
            bus.lane[k] = (dead_low && k < 8) ? 32'hDEADBEEF : W'($urandom());
        if (mode == LANES_0_15) begin
            for (int k = 0; k < 16; k++) bus.lane[k] = src[(c*16+k)*W +: W];
        end else if (mode == LANES_0_7) begin
            for (int k = 0; k < 8; k++) bus.lane[k] = src[(c*8+k)*W +: W];
        end else if (mode == LANES_8_15) begin
            for (int k = 0; k < 8; k++) bus.lane[8+k] = src[(c*8+k)*W +: W];
        end
    endtask

    task automatic send_beats(input logic [1:0] mode, input logic [FB-1:0] src, input int first,
                              input int last, input int gap_after, input int gap_len,
                              input bit dead_low);
        for (int c = first; c <= last; c++) begin
            bus.functional_rx_lanes = mode;
            set_lanes(mode, c, src, dead_low);
            bus.valid = 1'b1;
            @(posedge i_clk); #1;
            if (c == gap_after) begin
                bus.valid = 1'b0;
                repeat (gap_len) begin
                    set_lanes(LANES_NONE, 0, src, 1'b0);
                    @(posedge i_clk); #1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        bus.valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.valid = 1'b0;
        bus.functional_rx_lanes = LANES_NONE;
        bus.lane = '0;
        #12;
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL reset data_valid: got %b expected 0", bus.data_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
        n_cmp++; if (bus.out_data !== '0) begin n_fail++; print_frame_fail("reset out_data", bus.out_data, '0); end
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_lanes_0_7();
        logic [FB-1:0] src;
        int n0 = pulses;
        for (int c = 0; c < B8; c++)
            for (int k = 0; k < 8; k++)
                src[(c*8+k)*W +: W] = {8'(c), 8'(k), 16'hA5A5};
        send_beats(LANES_0_7, src, 0, 15, -1, 0, 1'b0);
        n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL l07 busy mid-frame: got %b expected 1", bus.busy); end
        send_beats(LANES_0_7, src, 16, B8 - 1, -1, 0, 1'b0);
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL l07 early valid: got %b expected 0", bus.data_valid); end
        idle(1);
        n_cmp++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL l07 valid latency: got %b expected 1", bus.data_valid); end
        n_cmp++; if (bus.out_data !== src) begin n_fail++; print_frame_fail("l07 data", bus.out_data, src); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL l07 busy after: got %b expected 0", bus.busy); end
        idle(1);
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL l07 pulse width: got %b expected 0", bus.data_valid); end
        n_cmp++; if (bus.out_data !== src) begin n_fail++; print_frame_fail("l07 hold", bus.out_data, src); end
        n_cmp++; if (pulses - n0 !== 1) begin n_fail++; $display("FAIL l07 pulse count: got %0d expected 1", pulses - n0); end
        last_frame = src;
    endtask

    task automatic test_lanes_8_15();
        logic [FB-1:0] src;
        int n0 = pulses;
        // Mode 00 with valid in IDLE must be ignored.
        bus.functional_rx_lanes = LANES_NONE;
        bus.valid = 1'b1;
        repeat (3) begin
            set_lanes(LANES_NONE, 0, src, 1'b0);
            @(posedge i_clk); #1;
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mode00 busy: got %b expected 0", bus.busy); end
        idle(2);
        n_cmp++; if (pulses !== n0) begin n_fail++; $display("FAIL mode00 pulse: got %0d expected %0d", pulses, n0); end
        gen_random(src);
        send_beats(LANES_8_15, src, 0, B8 - 1, -1, 0, 1'b1);
        idle(1);
        n_cmp++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL l815 valid: got %b expected 1", bus.data_valid); end
        n_cmp++; if (bus.out_data !== src) begin n_fail++; print_frame_fail("l815 data", bus.out_data, src); end
        idle(1);
        last_frame = src;
    endtask

    task automatic test_full_16();
        logic [FB-1:0] src;
        int n0 = pulses;
        for (int i = 0; i < NB; i++) src[i*8 +: 8] = 8'(i % 256);
        send_beats(LANES_0_15, src, 0, B16 - 1, -1, 0, 1'b0);
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL l16 early valid: got %b expected 0", bus.data_valid); end
        idle(1);
        n_cmp++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL l16 valid: got %b expected 1", bus.data_valid); end
        n_cmp++; if (bus.out_data !== src) begin n_fail++; print_frame_fail("l16 data", bus.out_data, src); end
        idle(1);
        n_cmp++; if (pulses - n0 !== 1) begin n_fail++; $display("FAIL l16 pulse count: got %0d expected 1", pulses - n0); end
        last_frame = src;
    endtask

    task automatic test_back_to_back();
        logic [FB-1:0] src1, src2;
        int n0 = pulses;
        int q0 = frames.size();
        int gap_at = int'($urandom_range(0, 13));
        gen_random(src1);
        gen_random(src2);
        send_beats(LANES_0_15, src1, 0, B16 - 1, gap_at, 3, 1'b0);
        send_beats(LANES_0_15, src2, 0, B16 - 1, -1, 0, 1'b0);
        idle(3);
        n_cmp++; if (pulses - n0 !== 2) begin n_fail++; $display("FAIL b2b pulse count: got %0d expected 2", pulses - n0); end
        if (frames.size() >= q0 + 2) begin
            n_cmp++; if (frames[q0] !== src1) begin n_fail++; print_frame_fail("b2b frame1", frames[q0], src1); end
            n_cmp++; if (frames[q0+1] !== src2) begin n_fail++; print_frame_fail("b2b frame2", frames[q0+1], src2); end
            n_cmp++; if (pulse_cyc[q0+1] - pulse_cyc[q0] !== int'(B16)) begin
                n_fail++;
                $display("FAIL b2b pulse spacing: got %0d expected %0d", pulse_cyc[q0+1] - pulse_cyc[q0], B16);
            end
        end else begin
            n_cmp++; n_fail++;
            $display("FAIL b2b frames captured: got %0d expected %0d", frames.size() - q0, 2);
        end
        last_frame = src2;
    endtask

    task automatic test_abort();
        logic [FB-1:0] srca, srcb;
        int n0 = pulses;
        gen_random(srca);
        gen_random(srcb);
        send_beats(LANES_0_7, srca, 0, 9, -1, 0, 1'b0);
        bus.functional_rx_lanes = LANES_0_15;
        set_lanes(LANES_0_15, 0, srca, 1'b0);
        bus.valid = 1'b1;
        @(posedge i_clk); #1;
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", bus.busy); end
        idle(3);
        n_cmp++; if (pulses !== n0) begin n_fail++; $display("FAIL abort pulse: got %0d expected %0d", pulses, n0); end
        n_cmp++; if (bus.out_data !== last_frame) begin n_fail++; print_frame_fail("abort out held", bus.out_data, last_frame); end
        send_beats(LANES_0_15, srcb, 0, B16 - 1, -1, 0, 1'b0);
        idle(1);
        n_cmp++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL abort recover valid: got %b expected 1", bus.data_valid); end
        n_cmp++; if (bus.out_data !== srcb) begin n_fail++; print_frame_fail("abort recover data", bus.out_data, srcb); end
        idle(1);
        last_frame = srcb;
    endtask

    task automatic test_reset_mid();
        logic [FB-1:0] src, src2;
        int n0 = pulses;
        gen_random(src);
        gen_random(src2);
        send_beats(LANES_0_7, src, 0, 19, -1, 0, 1'b0);
        set_lanes(LANES_0_7, 20, src, 1'b0);
        bus.valid = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_data !== '0) begin n_fail++; print_frame_fail("rstmid out_data", bus.out_data, '0); end
        n_cmp++; if (bus.data_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid data_valid: got %b expected 0", bus.data_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid busy: got %b expected 0", bus.busy); end
        bus.valid = 1'b0;
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        send_beats(LANES_0_7, src2, 0, B8 - 1, -1, 0, 1'b0);
        idle(1);
        n_cmp++; if (bus.data_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid fresh valid: got %b expected 1", bus.data_valid); end
        n_cmp++; if (bus.out_data !== src2) begin n_fail++; print_frame_fail("rstmid fresh data", bus.out_data, src2); end
        idle(2);
        n_cmp++; if (pulses - n0 !== 1) begin n_fail++; $display("FAIL rstmid pulse count: got %0d expected 1", pulses - n0); end
    endtask

    initial begin
        test_reset();
        test_lanes_0_7();
        test_lanes_8_15();
        test_full_16();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_to_byte_demapper.md
# lane_to_byte_demapper

RX-side demapper for the mainband datapath. It samples up to 16 received lanes of WIDTH bits each cycle and reassembles the lane beats into one N_BYTES-byte frame. Lanes are consumed in degraded mode (0–7 or 8–15) or full mode (0–15). The output is the exact inverse of the TX byte-to-lane order. The block sits between the RX lane deskew/descrambler stage and the RDI/adapter byte interface, and presents each completed frame with a one-cycle valid pulse.

## Interface
- WIDTH, 32, bits per lane per beat (multiple of 8)
- N_BYTES, 1024, bytes per reassembled frame
- NUM_LANES, 16, physical lanes (fixed at 16)
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_lane_0 … i_lane_15  in  WIDTH each  received lane data
- i_valid  in  1  beat qualifier; when 1, lanes are sampled on the rising edge
- i_functional_rx_lanes  in  2  01: lanes 0–7; 10: lanes 8–15; 11: lanes 0–15; 00: none
- o_out_data  out  8*N_BYTES  reassembled frame; byte 0 at bits [7:0]
- o_data_valid  out  1  one-cycle pulse, frame complete
- o_busy  out  1  high while a frame is partially collected

## Operation
- Beat width:
  - BEATS_8 = N_BYTES/(WIDTH/8)/8, which is 32 at the defaults.
  - BEATS_16 = N_BYTES/(WIDTH/8)/16, which is 16 at the defaults.
- States:
  - IDLE:
    - i_valid=1 with mode≠00 latches the mode into mode_q.
    - The beat is stored as beat 0 and the count is set to 1.
    - The state moves to COLLECT. If the frame needs only 1 beat, it moves to DONE instead.
  - COLLECT:
    - Each i_valid=1 stores the beat at index cnt and increments cnt.
    - When the beat with cnt = BEATS−1 is stored, the state goes to DONE.
  - DONE (one cycle):
    - The staging register is copied to o_out_data and o_data_valid is set to 1.
    - If i_valid=1 in the same cycle, that beat becomes beat 0 of the next frame and the state goes to COLLECT. This gives back-to-back frames with no bubble.
    - Otherwise the state goes to IDLE.
- Placement of beat c, chunk k:
  - 8-lane mode: chunk k (k = 0..7) comes from lane k (mode 01) or lane 8+k (mode 10). It is written to staging bits [(c*8+k)*WIDTH +: WIDTH].
  - 16-lane mode: chunk k (k = 0..15) comes from lane k. It is written to staging bits [(c*16+k)*WIDTH +: WIDTH].
- Unused lanes are ignored; their contents have no effect.
- Mode changes are handled as follows:
  - mode_q holds for the whole frame.
  - A change on i_functional_rx_lanes during COLLECT aborts the frame. cnt returns to 0 and the state goes to IDLE with no valid pulse.
  - The beat that arrives with the new mode is not consumed.
- i_valid=0 during COLLECT holds the state; gaps between beats are allowed.
- Mode 00 with i_valid=1 in IDLE is ignored.
- The staging register is not cleared between frames. Every slot is overwritten before the frame completes.

## Timing
- Reset values: o_out_data=0, o_data_valid=0, o_busy=0, state=IDLE, cnt=0, mode_q=00, staging=0.
- Latency: o_data_valid rises on the clock edge after the edge that samples the last beat, i.e. one cycle.
- o_out_data updates together with o_data_valid and holds until the next completed frame.
- o_busy = 1 in COLLECT, and in DONE when the next frame's first beat is taken. It is 0 otherwise.
- cnt is $clog2(BEATS_8) bits wide; it never wraps, because the state moves to DONE at BEATS−1.
- Minimum frame period is BEATS cycles. Sustained 8-lane throughput is one frame every 32 cycles at the defaults.
- Reset mid-frame discards the partial frame. o_out_data returns to 0 asynchronously.

## Structure
- Package ucie_mb_pkg: mode constants LANES_NONE=2'b00, LANES_0_7=2'b01, LANES_8_15=2'b10, LANES_0_15=2'b11, shared with the TX mapper.
- The package also holds the functions beats_8(N_BYTES, WIDTH) and beats_16(N_BYTES, WIDTH).
- Sub-module demap_beat_ctrl holds the FSM, cnt and mode_q, and outputs write-enable, slot index and done.
- The top level holds the lane mux and the staging and output registers.

## Test plan
- **8-lane, lanes 0–7:** drive mode 01 with 32 beats. Lane k on beat c carries {c[7:0], k[7:0], 16'hA5A5}. Expect o_data_valid one cycle after beat 31, and bits [(c*8+k)*32 +: 32] match the pattern; lanes 8–15 carry junk.
- **8-lane, lanes 8–15:** drive mode 10 with data only on lanes 8–15 and lanes 0–7 = 32'hDEADBEEF. Expect the frame to be rebuilt purely from lanes 8–15.
- **16-lane mode:** drive mode 11 with 16 beats. Expect a valid pulse after beat 15 and the full 8192-bit frame to match the source bytes 0..1023 = byte index mod 256.
- **Back-to-back with gaps:** send two mode-11 frames with an i_valid gap of 3 cycles inside frame 1, then frame 2 starting in the DONE cycle. Expect exactly two pulses, both frames correct, and no bubble between frames.
- **Abort on mode change:** switch mode 01→11 at beat 10. Expect no pulse and o_out_data unchanged, then a clean 16-beat frame to complete correctly.
- **Reset mid-frame:** assert i_rst_n=0 at beat 20 of an 8-lane frame. Expect all outputs 0 immediately; after release, a fresh 32-beat frame completes correctly.
